// File: rtl/ctrl_trace_pkg.sv
// Shared types and constants for the control-word trace buffer.
// Entries are packed {timestamp, stat, ctrl} with ctrl in the low bits.
package ctrl_trace_pkg;

  localparam int unsigned DefCwWidth    = 24;
  localparam int unsigned DefStWidth    = 2;
  localparam int unsigned DefDepth      = 16;
  localparam int unsigned DefTsWidth    = 16;
  localparam bit          DefStopOnFull = 1'b0;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRun    = 2'd1,
    StFrozen = 2'd2
  } trace_state_e;

  localparam int unsigned CtrlOffset = 0;

  function automatic int unsigned stat_offset(int unsigned cw_width);
    return cw_width;
  endfunction

  function automatic int unsigned ts_offset(int unsigned cw_width, int unsigned st_width);
    return cw_width + st_width;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Single-clock FIFO with a registered read port; clr flushes pointers and count.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       wr_en,
  input  logic [Width-1:0]           wr_data,
  input  logic                       rd_en,
  output logic                       rd_valid,
  output logic [Width-1:0]           rd_data,
  output logic [$clog2(Depth):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic [Width-1:0] rd_data_q, rd_data_d;
  logic             push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(Depth));
  assign pop   = rd_en && !empty && !clr;
  assign push  = wr_en && !clr && (!full || pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_d  = rd_ptr_q + PtrW'(1);
        rd_data_d = mem_q[rd_ptr_q];
      end
      rd_valid_d = pop;
      count_d    = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Storage is never reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

  assign count    = count_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: rtl/ctrl_trace_buffer.sv
// Registers the control word and status strobes and logs timestamped snapshots
// into a FIFO, either every enabled cycle or on masked control-word changes.
module ctrl_trace_buffer
  import ctrl_trace_pkg::*;
#(
  parameter int unsigned CW_WIDTH     = DefCwWidth,
  parameter int unsigned ST_WIDTH     = DefStWidth,
  parameter int unsigned DEPTH        = DefDepth,
  parameter int unsigned TS_WIDTH     = DefTsWidth,
  parameter bit          STOP_ON_FULL = DefStopOnFull
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   en,
  input  logic                                   mode,
  input  logic [CW_WIDTH-1:0]                    trig_mask,
  input  logic                                   clear,
  input  logic [CW_WIDTH-1:0]                    ctrl_in,
  input  logic [ST_WIDTH-1:0]                    stat_in,
  output logic [CW_WIDTH-1:0]                    ctrl_q,
  output logic [ST_WIDTH-1:0]                    stat_q,
  input  logic                                   rd_en,
  output logic                                   rd_valid,
  output logic [TS_WIDTH+ST_WIDTH+CW_WIDTH-1:0]  rd_data,
  output logic [$clog2(DEPTH):0]                 count,
  output logic                                   empty,
  output logic                                   full,
  output logic                                   overflow,
  output logic                                   frozen
);

  localparam int unsigned EntryW  = TS_WIDTH + ST_WIDTH + CW_WIDTH;
  localparam int unsigned StatLsb = stat_offset(CW_WIDTH);
  localparam int unsigned TsLsb   = ts_offset(CW_WIDTH, ST_WIDTH);

  logic [CW_WIDTH-1:0] ctrl_d;
  logic [ST_WIDTH-1:0] stat_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  trace_state_e        state_q, state_d;
  logic                overflow_q, overflow_d;
  logic                trig, capture, drop;
  logic [EntryW-1:0]   entry;

  // Change detection compares against last cycle's registered word.
  assign trig    = en && (!mode || |((ctrl_in ^ ctrl_q) & trig_mask));
  assign capture = (state_q == StRun) && trig && !clear;
  // A same-cycle pop frees a slot, so a full FIFO only drops without rd_en.
  assign drop    = capture && full && !rd_en;

  always_comb begin
    entry = '0;
    entry[CtrlOffset +: CW_WIDTH] = ctrl_in;
    entry[StatLsb +: ST_WIDTH]    = stat_in;
    entry[TsLsb +: TS_WIDTH]      = ts_q;
  end

  always_comb begin
    ctrl_d     = ctrl_in;
    stat_d     = stat_in;
    ts_d       = clear ? '0 : ts_q + TS_WIDTH'(1);
    overflow_d = clear ? 1'b0 : (overflow_q || drop);
    state_d    = state_q;
    if (clear) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:   if (en) state_d = StRun;
        StRun: begin
          if (drop && STOP_ON_FULL) state_d = StFrozen;
          else if (!en)             state_d = StIdle;
        end
        StFrozen: state_d = StFrozen;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      stat_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      state_q    <= StIdle;
    end else begin
      ctrl_q     <= ctrl_d;
      stat_q     <= stat_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  trace_fifo #(
    .Width (EntryW),
    .Depth (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clear),
    .wr_en    (capture),
    .wr_data  (entry),
    .rd_en    (rd_en),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  assign overflow = overflow_q;
  assign frozen   = (state_q == StFrozen);

endmodule

// File: tb/tb_ctrl_trace_buffer.sv
// Directed bench for ctrl_trace_buffer: one instance drops when full, a second
// freezes when full; both share the same stimulus.
module tb_ctrl_trace_buffer;

  logic        clk = 1'b0;
  logic        rst, en, mode, clear, rd_en;
  logic [23:0] trig_mask, ctrl_in;
  logic [1:0]  stat_in;

  logic [23:0] ctrl_q, s_ctrl_q;
  logic [1:0]  stat_q, s_stat_q;
  logic        rd_valid, s_rd_valid;
  logic [41:0] rd_data, s_rd_data;
  logic [4:0]  count, s_count;
  logic        empty, s_empty, full, s_full, overflow, s_overflow, frozen, s_frozen;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ctrl_trace_buffer #(.STOP_ON_FULL(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig_mask(trig_mask), .clear(clear),
    .ctrl_in(ctrl_in), .stat_in(stat_in), .ctrl_q(ctrl_q), .stat_q(stat_q), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .frozen(frozen)
  );

  ctrl_trace_buffer #(.STOP_ON_FULL(1'b1)) dut_stop (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .trig_mask(trig_mask), .clear(clear),
    .ctrl_in(ctrl_in), .stat_in(stat_in), .ctrl_q(s_ctrl_q), .stat_q(s_stat_q), .rd_en(rd_en),
    .rd_valid(s_rd_valid), .rd_data(s_rd_data), .count(s_count), .empty(s_empty),
    .full(s_full), .overflow(s_overflow), .frozen(s_frozen)
  );

  function automatic logic [41:0] ent(int ts, int st, int cw);
    return {16'(ts), 2'(st), 24'(cw)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; mode = 1'b0; clear = 1'b0; rd_en = 1'b0;
    trig_mask = '0; ctrl_in = '0; stat_in = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; mode = 1'b0; clear = 1'b0; rd_en = 1'b0;
    trig_mask = '0; ctrl_in = 24'hABCDEF; stat_in = 2'b11;
    step();
    checks++; if (ctrl_q !== 24'h0) begin failures++; $display("FAIL reset_ctrl_q got=%0h exp=0", ctrl_q); end
    checks++; if (rd_data !== 42'h0 || rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd got=%0h/%0b exp=0/0", rd_data, rd_valid); end
    checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_count got=%0d/%0b/%0b exp=0/1/0", count, empty, full); end
    checks++; if (overflow !== 1'b0 || frozen !== 1'b0 || s_frozen !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b/%0b/%0b exp=0/0/0", overflow, frozen, s_frozen); end
    rst = 1'b0; en = 1'b0;
    step();
    checks++; if (ctrl_q !== 24'hABCDEF || stat_q !== 2'b11) begin failures++; $display("FAIL reg_latency got=%0h/%0h exp=abcdef/3", ctrl_q, stat_q); end
    ctrl_in = 24'h123456; stat_in = 2'b01;
    step();
    checks++; if (ctrl_q !== 24'h123456 || stat_q !== 2'b01) begin failures++; $display("FAIL reg_follow got=%0h/%0h exp=123456/1", ctrl_q, stat_q); end
  endtask

  task automatic test_mode0();
    do_reset();
    en = 1'b1;
    step();  // first enabled cycle only moves IDLE -> RUN
    for (int i = 1; i <= 4; i++) begin
      ctrl_in = 24'(i); stat_in = 2'(i);
      step();
    end
    en = 1'b0;
    step();
    checks++; if (count !== 5'd4) begin failures++; $display("FAIL mode0_count got=%0d exp=4", count); end
    rd_en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (rd_valid !== 1'b1 || rd_data !== ent(i, i % 4, i)) begin failures++; $display("FAIL mode0_pop%0d got=%0b/%0h exp=1/%0h", i, rd_valid, rd_data, ent(i, i % 4, i)); end
    end
    step();
    checks++; if (rd_valid !== 1'b0 || empty !== 1'b1) begin failures++; $display("FAIL mode0_underflow got=%0b/%0b exp=0/1", rd_valid, empty); end
    rd_en = 1'b0;
  endtask

  task automatic test_mode1();
    do_reset();
    mode = 1'b1; trig_mask = 24'h000F00; en = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      ctrl_in = (k % 2 == 0) ? 24'h1 : 24'h0;
      step();
    end
    ctrl_in = 24'h101;
    step();
    step();
    en = 1'b0;
    step();
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL mode1_count got=%0d exp=1", count); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ent(6, 0, 24'h101)) begin failures++; $display("FAIL mode1_entry got=%0h exp=%0h", rd_data, ent(6, 0, 24'h101)); end
    mode = 1'b0; trig_mask = '0;
  endtask

  task automatic test_overflow();
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      ctrl_in = 24'(i + 1);
      step();
    end
    en = 1'b0;
    step();
    checks++; if (count !== 5'd16 || full !== 1'b1) begin failures++; $display("FAIL ovf_count got=%0d/%0b exp=16/1", count, full); end
    checks++; if (overflow !== 1'b1 || frozen !== 1'b0) begin failures++; $display("FAIL ovf_flags got=%0b/%0b exp=1/0", overflow, frozen); end
    checks++; if (s_frozen !== 1'b1 || s_count !== 5'd16) begin failures++; $display("FAIL stop_inst got=%0b/%0d exp=1/16", s_frozen, s_count); end
    rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      checks++; if (rd_data !== ent(i + 1, 0, i + 1)) begin failures++; $display("FAIL ovf_pop%0d got=%0h exp=%0h", i, rd_data, ent(i + 1, 0, i + 1)); end
    end
    rd_en = 1'b0;
    step();
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%0b/%0b exp=1/1", empty, overflow); end
  endtask

  task automatic test_stop_on_full();
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      ctrl_in = 24'(32'h100 + i);
      step();
    end
    checks++; if (s_full !== 1'b1 || s_frozen !== 1'b0) begin failures++; $display("FAIL stop_fill got=%0b/%0b exp=1/0", s_full, s_frozen); end
    ctrl_in = 24'hAAA;
    step();
    checks++; if (s_frozen !== 1'b1 || s_overflow !== 1'b1 || s_count !== 5'd16) begin failures++; $display("FAIL stop_freeze got=%0b/%0b/%0d exp=1/1/16", s_frozen, s_overflow, s_count); end
    for (int i = 0; i < 3; i++) begin
      ctrl_in = 24'(32'hB00 + i);
      step();
    end
    checks++; if (s_frozen !== 1'b1 || s_count !== 5'd16) begin failures++; $display("FAIL stop_hold got=%0b/%0d exp=1/16", s_frozen, s_count); end
    en = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (s_count !== 5'd0 || s_frozen !== 1'b0 || s_overflow !== 1'b0 || s_empty !== 1'b1) begin failures++; $display("FAIL stop_clear got=%0d/%0b/%0b/%0b exp=0/0/0/1", s_count, s_frozen, s_overflow, s_empty); end
    en = 1'b1; ctrl_in = 24'h5;
    step();
    checks++; if (s_count !== 5'd0) begin failures++; $display("FAIL clear_idle got=%0d exp=0", s_count); end
    ctrl_in = 24'h6;
    step();
    en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (s_rd_valid !== 1'b1 || s_rd_data !== ent(1, 0, 6)) begin failures++; $display("FAIL clear_ts got=%0h exp=%0h", s_rd_data, ent(1, 0, 6)); end
  endtask

  task automatic test_full_rw();
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 16; i++) begin
      ctrl_in = 24'(32'h200 + i);
      step();
    end
    ctrl_in = 24'h3FF; rd_en = 1'b1;
    step();
    en = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd16 || overflow !== 1'b0 || s_frozen !== 1'b0) begin failures++; $display("FAIL full_rw got=%0d/%0b/%0b exp=16/0/0", count, overflow, s_frozen); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== ent(1, 0, 24'h200)) begin failures++; $display("FAIL full_rw_data got=%0h exp=%0h", rd_data, ent(1, 0, 24'h200)); end
    step();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_one_cycle got=%0b exp=0", rd_valid); end
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      if (i == 16) begin
        checks++; if (rd_data !== ent(17, 0, 24'h3FF)) begin failures++; $display("FAIL full_rw_newest got=%0h exp=%0h", rd_data, ent(17, 0, 24'h3FF)); end
      end else begin
        checks++; if (rd_data !== ent(i + 1, 0, 32'h200 + i)) begin failures++; $display("FAIL full_rw_pop%0d got=%0h exp=%0h", i, rd_data, ent(i + 1, 0, 32'h200 + i)); end
      end
    end
    rd_en = 1'b0;
  endtask

  task automatic test_empty_rw();
    do_reset();
    en = 1'b1;
    step();
    ctrl_in = 24'h77; rd_en = 1'b1;
    step();
    en = 1'b0; rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin failures++; $display("FAIL empty_rw got=%0b/%0d/%0b exp=0/1/0", rd_valid, count, empty); end
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (rd_valid !== 1'b1 || rd_data !== ent(1, 0, 24'h77)) begin failures++; $display("FAIL empty_rw_data got=%0h exp=%0h", rd_data, ent(1, 0, 24'h77)); end
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      ctrl_in = 24'(32'h10 + i);
      step();
    end
    checks++; if (count !== 5'd7) begin failures++; $display("FAIL rst_pre got=%0d exp=7", count); end
    rst = 1'b1; rd_en = 1'b1; ctrl_in = 24'h55;
    step();
    rst = 1'b0; rd_en = 1'b0;
    checks++; if (count !== 5'd0 || empty !== 1'b1 || ctrl_q !== 24'h0 || rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid got=%0d/%0b/%0h/%0b exp=0/1/0/0", count, empty, ctrl_q, rd_valid); end
    ctrl_in = 24'h0;
    step();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL rst_idle got=%0d exp=0", count); end
    ctrl_in = 24'h99;
    step();
    en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    checks++; if (rd_data !== ent(1, 0, 24'h99)) begin failures++; $display("FAIL rst_ts got=%0h exp=%0h", rd_data, ent(1, 0, 24'h99)); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_mode1();
    test_overflow();
    test_stop_on_full();
    test_full_rw();
    test_empty_rw();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
